// File: rtl/bids22_pkg.sv
// Shared definitions for the BIDS22 host-side sequencer: engine opcodes, sequencer
// states, error codes and the configuration-phase command table.
package bids22_pkg;

    localparam logic [3:0] OP_NOP        = 4'd0;
    localparam logic [3:0] OP_UNLOCK     = 4'd1;
    localparam logic [3:0] OP_LOCK       = 4'd2;
    localparam logic [3:0] OP_LOAD_X     = 4'd3;
    localparam logic [3:0] OP_LOAD_Y     = 4'd4;
    localparam logic [3:0] OP_LOAD_Z     = 4'd5;
    localparam logic [3:0] OP_SET_MASK   = 4'd6;
    localparam logic [3:0] OP_SET_TIMER  = 4'd7;
    localparam logic [3:0] OP_BID_CHARGE = 4'd8;

    localparam int CFG_OPS = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_ROUND,
        ST_DRAIN,
        ST_OVER,
        ST_DONE,
        ST_ERROR
    } seq_state_e;

    localparam logic [2:0] SEQ_ERR_CFG        = 3'b001;
    localparam logic [2:0] SEQ_ERR_START      = 3'b011;
    localparam logic [2:0] SEQ_ERR_ROUND_OVER = 3'b100;
    localparam logic [2:0] SEQ_ERR_UNLOCK     = 3'b101;

    localparam logic [2:0] ENG_ERR_NONE     = 3'b000;
    localparam logic [2:0] ENG_ERR_LOCKED   = 3'b001;
    localparam logic [2:0] ENG_ERR_BAD_KEY  = 3'b010;
    localparam logic [2:0] ENG_ERR_BAD_OP   = 3'b011;
    localparam logic [2:0] ENG_ERR_BAD_DATA = 3'b100;

    // Data sources are named rather than carried, so the table stays width-agnostic.
    typedef enum logic [2:0] {
        SRC_X,
        SRC_Y,
        SRC_Z,
        SRC_MASK,
        SRC_TIMER,
        SRC_COST,
        SRC_KEY
    } cfg_src_e;

    typedef struct packed {
        logic [3:0] op;
        cfg_src_e   src;
    } cfg_cmd_t;

    function automatic cfg_cmd_t cfg_cmd(input logic [2:0] idx);
        cfg_cmd_t c;
        case (idx)
            3'd0:    c = '{op: OP_LOAD_X,     src: SRC_X};
            3'd1:    c = '{op: OP_LOAD_Y,     src: SRC_Y};
            3'd2:    c = '{op: OP_LOAD_Z,     src: SRC_Z};
            3'd3:    c = '{op: OP_SET_MASK,   src: SRC_MASK};
            3'd4:    c = '{op: OP_SET_TIMER,  src: SRC_TIMER};
            3'd5:    c = '{op: OP_BID_CHARGE, src: SRC_COST};
            default: c = '{op: OP_LOCK,       src: SRC_KEY};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bids22_round_sequencer.sv
// Drives the BIDS22 engine command port through one full session per go pulse:
// configure, lock, run the bidding rounds, then unlock.
module bids22_round_sequencer
    import bids22_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RND_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [DATA_W-1:0] cfg_key,
    input  logic [DATA_W-1:0] cfg_x_init,
    input  logic [DATA_W-1:0] cfg_y_init,
    input  logic [DATA_W-1:0] cfg_z_init,
    input  logic [2:0]        cfg_mask,
    input  logic [3:0]        cfg_timer,
    input  logic [DATA_W-1:0] cfg_bid_cost,
    input  logic [RND_W-1:0]  cfg_rounds,
    input  logic [RND_W-1:0]  cfg_round_len,
    input  logic              ready,
    input  logic [2:0]        err,
    input  logic              roundOver,
    input  logic [DATA_W-1:0] maxBid,
    input  logic              X_win,
    input  logic              Y_win,
    input  logic              Z_win,
    output logic [3:0]        C_op,
    output logic [DATA_W-1:0] C_data,
    output logic              C_start,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [DATA_W-1:0] last_max_bid,
    output logic [2:0]        last_winner,
    output logic [RND_W-1:0]  round_count,
    output logic              seq_err,
    output logic [2:0]        seq_err_code
);

    seq_state_e        state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic              issued_q, issued_d;
    logic [RND_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] x_init_q, x_init_d;
    logic [DATA_W-1:0] y_init_q, y_init_d;
    logic [DATA_W-1:0] z_init_q, z_init_d;
    logic [2:0]        mask_q, mask_d;
    logic [3:0]        timer_q, timer_d;
    logic [DATA_W-1:0] cost_q, cost_d;
    logic [RND_W-1:0]  rounds_q, rounds_d;
    logic [RND_W-1:0]  len_q, len_d;

    logic [3:0]        c_op_q, c_op_d;
    logic [DATA_W-1:0] c_data_q, c_data_d;
    logic              c_start_q, c_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              result_valid_q, result_valid_d;
    logic [DATA_W-1:0] last_max_bid_q, last_max_bid_d;
    logic [2:0]        last_winner_q, last_winner_d;
    logic [RND_W-1:0]  round_count_q, round_count_d;
    logic              seq_err_q, seq_err_d;
    logic [2:0]        seq_err_code_q, seq_err_code_d;

    logic [2:0]        next_idx;
    cfg_cmd_t          cmd;
    logic [DATA_W-1:0] cmd_data;
    logic              last_round;
    logic              fault;
    logic [2:0]        fault_code;

    // An op only advances the index once it was actually presented to the engine.
    assign next_idx   = issued_q ? idx_q + 3'd1 : idx_q;
    assign last_round = (round_count_q == rounds_q - RND_W'(1));

    always_comb begin
        cmd      = cfg_cmd(next_idx);
        cmd_data = '0;
        case (cmd.src)
            SRC_X:     cmd_data = x_init_q;
            SRC_Y:     cmd_data = y_init_q;
            SRC_Z:     cmd_data = z_init_q;
            SRC_MASK:  cmd_data = DATA_W'(mask_q);
            SRC_TIMER: cmd_data = DATA_W'(timer_q);
            SRC_COST:  cmd_data = cost_q;
            SRC_KEY:   cmd_data = key_q;
            default:   cmd_data = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        issued_d       = issued_q;
        cnt_d          = cnt_q;
        key_d          = key_q;
        x_init_d       = x_init_q;
        y_init_d       = y_init_q;
        z_init_d       = z_init_q;
        mask_d         = mask_q;
        timer_d        = timer_q;
        cost_d         = cost_q;
        rounds_d       = rounds_q;
        len_d          = len_q;
        c_op_d         = OP_NOP;
        c_data_d       = '0;
        c_start_d      = 1'b0;
        busy_d         = busy_q;
        done_d         = 1'b0;
        result_valid_d = 1'b0;
        last_max_bid_d = last_max_bid_q;
        last_winner_d  = last_winner_q;
        round_count_d  = round_count_q;
        seq_err_d      = seq_err_q;
        seq_err_code_d = seq_err_code_q;
        fault          = 1'b0;
        fault_code     = '0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    key_d         = cfg_key;
                    x_init_d      = cfg_x_init;
                    y_init_d      = cfg_y_init;
                    z_init_d      = cfg_z_init;
                    mask_d        = cfg_mask;
                    timer_d       = cfg_timer;
                    cost_d        = cfg_bid_cost;
                    rounds_d      = cfg_rounds;
                    len_d         = (cfg_round_len == '0) ? RND_W'(1) : cfg_round_len;
                    round_count_d = '0;
                    if (cfg_rounds == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d  = ST_CFG;
                        busy_d   = 1'b1;
                        idx_d    = 3'd0;
                        issued_d = ready;
                        if (ready) begin
                            c_op_d   = OP_LOAD_X;
                            c_data_d = cfg_x_init;
                        end
                    end
                end
            end
            ST_CFG: begin
                if (issued_q && err != ENG_ERR_NONE) begin
                    fault      = 1'b1;
                    fault_code = SEQ_ERR_CFG;
                end else if (issued_q && idx_q == 3'(CFG_OPS - 1)) begin
                    state_d   = ST_ROUND;
                    cnt_d     = '0;
                    c_start_d = 1'b1;
                end else begin
                    idx_d    = next_idx;
                    issued_d = ready;
                    if (ready) begin
                        c_op_d   = cmd.op;
                        c_data_d = cmd_data;
                    end
                end
            end
            ST_ROUND: begin
                // cnt_q == 0 marks the start cycle; later cycles are player activity.
                if (cnt_q == '0 && err != ENG_ERR_NONE) begin
                    fault      = 1'b1;
                    fault_code = SEQ_ERR_START;
                end else if (cnt_q == len_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d     = cnt_q + RND_W'(1);
                    c_start_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_OVER;
                if (last_round) begin
                    c_op_d   = OP_UNLOCK;
                    c_data_d = key_q;
                end else begin
                    c_start_d = 1'b1;
                end
            end
            ST_OVER: begin
                if (!roundOver) begin
                    fault      = 1'b1;
                    fault_code = SEQ_ERR_ROUND_OVER;
                end else begin
                    last_max_bid_d = maxBid;
                    last_winner_d  = {X_win, Y_win, Z_win};
                    result_valid_d = 1'b1;
                    round_count_d  = round_count_q + RND_W'(1);
                    if (last_round) begin
                        if (err != ENG_ERR_NONE) begin
                            fault      = 1'b1;
                            fault_code = SEQ_ERR_UNLOCK;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else if (err != ENG_ERR_NONE) begin
                        // This cycle doubled as the next round's start cycle.
                        fault      = 1'b1;
                        fault_code = SEQ_ERR_START;
                    end else begin
                        state_d   = ST_ROUND;
                        cnt_d     = RND_W'(1);
                        c_start_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fault) begin
            state_d   = ST_ERROR;
            busy_d    = 1'b0;
            seq_err_d = 1'b1;
            c_op_d    = OP_NOP;
            c_data_d  = '0;
            c_start_d = 1'b0;
            if (!seq_err_q) begin
                seq_err_code_d = fault_code;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            issued_q       <= 1'b0;
            cnt_q          <= '0;
            key_q          <= '0;
            x_init_q       <= '0;
            y_init_q       <= '0;
            z_init_q       <= '0;
            mask_q         <= '0;
            timer_q        <= '0;
            cost_q         <= '0;
            rounds_q       <= '0;
            len_q          <= '0;
            c_op_q         <= OP_NOP;
            c_data_q       <= '0;
            c_start_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            last_max_bid_q <= '0;
            last_winner_q  <= '0;
            round_count_q  <= '0;
            seq_err_q      <= 1'b0;
            seq_err_code_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            issued_q       <= issued_d;
            cnt_q          <= cnt_d;
            key_q          <= key_d;
            x_init_q       <= x_init_d;
            y_init_q       <= y_init_d;
            z_init_q       <= z_init_d;
            mask_q         <= mask_d;
            timer_q        <= timer_d;
            cost_q         <= cost_d;
            rounds_q       <= rounds_d;
            len_q          <= len_d;
            c_op_q         <= c_op_d;
            c_data_q       <= c_data_d;
            c_start_q      <= c_start_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            last_max_bid_q <= last_max_bid_d;
            last_winner_q  <= last_winner_d;
            round_count_q  <= round_count_d;
            seq_err_q      <= seq_err_d;
            seq_err_code_q <= seq_err_code_d;
        end
    end

    assign C_op         = c_op_q;
    assign C_data       = c_data_q;
    assign C_start      = c_start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign last_max_bid = last_max_bid_q;
    assign last_winner  = last_winner_q;
    assign round_count  = round_count_q;
    assign seq_err      = seq_err_q;
    assign seq_err_code = seq_err_code_q;

endmodule

// File: tb/tb_bids22_round_sequencer.sv
// Scoreboard bench for bids22_round_sequencer with a minimal engine stand-in that
// raises roundOver after each round and reports a fixed max bid / winner per round.
module tb_bids22_round_sequencer;
    import bids22_pkg::*;

    localparam int DATA_W = 32;
    localparam int RND_W  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              go = 1'b0;
    logic [DATA_W-1:0] cfg_key = '0, cfg_x_init = '0, cfg_y_init = '0, cfg_z_init = '0;
    logic [2:0]        cfg_mask = '0;
    logic [3:0]        cfg_timer = '0;
    logic [DATA_W-1:0] cfg_bid_cost = '0;
    logic [RND_W-1:0]  cfg_rounds = '0, cfg_round_len = '0;
    logic              ready = 1'b1;
    logic [2:0]        err;
    logic              roundOver;
    logic [DATA_W-1:0] maxBid;
    logic              X_win, Y_win, Z_win;
    logic [3:0]        C_op;
    logic [DATA_W-1:0] C_data;
    logic              C_start, busy, done, result_valid, seq_err;
    logic [DATA_W-1:0] last_max_bid;
    logic [2:0]        last_winner, seq_err_code;
    logic [RND_W-1:0]  round_count;

    always #5 clk = ~clk;

    bids22_round_sequencer #(.DATA_W(DATA_W), .RND_W(RND_W)) dut (
        .clk(clk), .reset_n(reset_n), .go(go),
        .cfg_key(cfg_key), .cfg_x_init(cfg_x_init), .cfg_y_init(cfg_y_init),
        .cfg_z_init(cfg_z_init), .cfg_mask(cfg_mask), .cfg_timer(cfg_timer),
        .cfg_bid_cost(cfg_bid_cost), .cfg_rounds(cfg_rounds), .cfg_round_len(cfg_round_len),
        .ready(ready), .err(err), .roundOver(roundOver), .maxBid(maxBid),
        .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
        .C_op(C_op), .C_data(C_data), .C_start(C_start), .busy(busy), .done(done),
        .result_valid(result_valid), .last_max_bid(last_max_bid), .last_winner(last_winner),
        .round_count(round_count), .seq_err(seq_err), .seq_err_code(seq_err_code)
    );

    // Engine stand-in: round k (from 0) reports maxBid 10+5k and winner 100>>k.
    logic        inj_err = 1'b0;
    logic        prev_start;
    logic [31:0] eng_max;
    logic [2:0]  eng_win;
    int          rnd;

    assign err    = (inj_err && C_op == OP_SET_MASK) ? 3'b100 : 3'b000;
    assign maxBid = eng_max;
    assign {X_win, Y_win, Z_win} = eng_win;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_start <= 1'b0;
            roundOver  <= 1'b0;
            eng_max    <= '0;
            eng_win    <= '0;
            rnd        <= 0;
        end else begin
            prev_start <= C_start;
            roundOver  <= !C_start && prev_start;
            if (go && !busy) begin
                rnd <= 0;
            end else if (!C_start && prev_start) begin
                eng_max <= 32'(10 + 5 * rnd);
                eng_win <= 3'b100 >> rnd;
                rnd     <= rnd + 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [3:0] op; logic [31:0] data; } op_t;
    typedef struct packed { logic [31:0] mb; logic [2:0] win; logic [7:0] rc; } res_t;

    op_t  op_q[$];
    res_t res_q[$];
    int   done_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   go_cyc = 0;
    int   start_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an op, a result or done.
    always @(negedge clk) begin
        if (reset_n) begin
            if (C_start) start_cnt++;
            if (C_op != OP_NOP) begin
                if (op_q.size() == 0) begin
                    unexpected("op_unexpected", {28'd0, C_op, C_data});
                end else begin
                    op_t e;
                    e = op_q.pop_front();
                    $display("op %0d data %0h (cycle %0d)", C_op, C_data, cyc);
                    chk("op_code", C_op, e.op);
                    chk("op_data", C_data, e.data);
                end
            end
            if (result_valid) begin
                if (res_q.size() == 0) begin
                    unexpected("result_unexpected", last_max_bid);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    $display("result max_bid %0d winner %b round_count %0d", last_max_bid, last_winner, round_count);
                    chk("result_max_bid", last_max_bid, r.mb);
                    chk("result_winner", last_winner, r.win);
                    chk("result_round_count", round_count, r.rc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    unexpected("done_unexpected", cyc - go_cyc);
                end else begin
                    int d;
                    d = done_q.pop_front();
                    $display("done after %0d cycles", cyc - go_cyc);
                    chk("done_latency", cyc - go_cyc, d);
                    chk("busy_at_done", busy, 0);
                end
            end
        end
    end

    task automatic set_cfg(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                           input logic [2:0] m, input logic [3:0] t, input logic [31:0] c,
                           input logic [7:0] r, input logic [7:0] l, input logic [31:0] k);
        cfg_x_init = x; cfg_y_init = y; cfg_z_init = z; cfg_mask = m; cfg_timer = t;
        cfg_bid_cost = c; cfg_rounds = r; cfg_round_len = l; cfg_key = k;
    endtask

    task automatic push_cfg_ops(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                                input logic [31:0] m, input logic [31:0] t, input logic [31:0] c,
                                input logic [31:0] k);
        op_q.push_back('{op: 4'd3, data: x});
        op_q.push_back('{op: 4'd4, data: y});
        op_q.push_back('{op: 4'd5, data: z});
        op_q.push_back('{op: 4'd6, data: m});
        op_q.push_back('{op: 4'd7, data: t});
        op_q.push_back('{op: 4'd8, data: c});
        op_q.push_back('{op: 4'd2, data: k});
    endtask

    // Called on a negedge; go is held for exactly one rising edge.
    task automatic start_go();
        go = 1'b1;
        go_cyc = cyc;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) unexpected("session_timeout", n);
        repeat (2) @(negedge clk);
        chk("op_queue_drained", op_q.size(), 0);
        chk("result_queue_drained", res_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_C_op"}, C_op, 0);
        chk({tag, "_C_data"}, C_data, 0);
        chk({tag, "_C_start"}, C_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_last_max_bid"}, last_max_bid, 0);
        chk({tag, "_last_winner"}, last_winner, 0);
        chk({tag, "_round_count"}, round_count, 0);
        chk({tag, "_seq_err"}, seq_err, 0);
        chk({tag, "_seq_err_code"}, seq_err_code, 0);
    endtask

    initial begin
        int s0;
        int n;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Basic session: one round of length 2, winner X with bid 10.
        push_cfg_ops(100, 200, 50, 7, 4, 1, 32'hA5A5);
        op_q.push_back('{op: 4'd1, data: 32'hA5A5});
        res_q.push_back('{mb: 32'd10, win: 3'b100, rc: 8'd1});
        done_q.push_back(13);
        set_cfg(100, 200, 50, 3'b111, 4'd4, 1, 8'd1, 8'd2, 32'hA5A5);
        s0 = start_cnt;
        start_go();
        wait_end(100);
        chk("basic_start_cycles", start_cnt - s0, 3);
        chk("basic_busy_after", busy, 0);
        chk("basic_round_count", round_count, 1);

        // Three rounds of length 1; a go with different cfg mid-session must be ignored.
        push_cfg_ops(300, 400, 500, 3, 2, 5, 32'h1234);
        op_q.push_back('{op: 4'd1, data: 32'h1234});
        res_q.push_back('{mb: 32'd10, win: 3'b100, rc: 8'd1});
        res_q.push_back('{mb: 32'd15, win: 3'b010, rc: 8'd2});
        res_q.push_back('{mb: 32'd20, win: 3'b001, rc: 8'd3});
        done_q.push_back(18);
        set_cfg(300, 400, 500, 3'b011, 4'd2, 5, 8'd3, 8'd1, 32'h1234);
        s0 = start_cnt;
        start_go();
        repeat (2) @(negedge clk);
        set_cfg(1, 2, 3, 3'b001, 4'd9, 9, 8'd0, 8'd7, 32'hDEAD);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_end(100);
        chk("multi_start_cycles", start_cnt - s0, 6);
        chk("multi_round_count", round_count, 3);

        // Zero rounds: done on the very next cycle, no engine ops at all.
        done_q.push_back(1);
        set_cfg(7, 8, 9, 3'b101, 4'd1, 2, 8'd0, 8'd3, 32'h55);
        start_go();
        wait_end(20);
        chk("zero_round_count", round_count, 0);
        chk("zero_seq_err", seq_err, 0);

        // Ready stall straight after reset; cfg changes after acceptance are ignored.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        push_cfg_ops(100, 200, 50, 7, 4, 1, 32'hA5A5);
        op_q.push_back('{op: 4'd1, data: 32'hA5A5});
        res_q.push_back('{mb: 32'd10, win: 3'b100, rc: 8'd1});
        done_q.push_back(17);
        set_cfg(100, 200, 50, 3'b111, 4'd4, 1, 8'd1, 8'd2, 32'hA5A5);
        start_go();
        chk("stall_nop_0", C_op, 0);
        cfg_x_init = 999;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("stall_nop_%0d", i), C_op, 0);
        end
        ready = 1'b1;
        wait_end(100);
        chk("stall_seq_err", seq_err, 0);

        // Engine error on SetMask: sticky ERROR, code 001, later go ignored.
        inj_err = 1'b1;
        op_q.push_back('{op: 4'd3, data: 32'd100});
        op_q.push_back('{op: 4'd4, data: 32'd200});
        op_q.push_back('{op: 4'd5, data: 32'd50});
        op_q.push_back('{op: 4'd6, data: 32'd7});
        set_cfg(100, 200, 50, 3'b111, 4'd4, 1, 8'd1, 8'd2, 32'hA5A5);
        start_go();
        wait_end(50);
        chk("err_seq_err", seq_err, 1);
        chk("err_code", seq_err_code, 3'b001);
        chk("err_busy", busy, 0);
        chk("err_C_start", C_start, 0);
        inj_err = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (6) @(negedge clk);
        chk("err_go_ignored_busy", busy, 0);
        chk("err_go_ignored_op", C_op, 0);
        chk("err_code_kept", seq_err_code, 3'b001);

        // Reset in the middle of a round clears everything asynchronously.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push_cfg_ops(11, 22, 33, 6, 3, 2, 32'hBEEF);
        set_cfg(11, 22, 33, 3'b110, 4'd3, 2, 8'd2, 8'd4, 32'hBEEF);
        start_go();
        n = 0;
        while (!C_start && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) unexpected("round_start_timeout", n);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midreset_idle_busy", busy, 0);
        chk("midreset_ops_consumed", op_q.size(), 0);
        done_q.push_back(1);
        set_cfg(0, 0, 0, 3'b000, 4'd0, 0, 8'd0, 8'd0, 0);
        start_go();
        wait_end(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bids22_round_sequencer.md
Name: bids22_round_sequencer

Overview:
Host-side controller that sequences the BIDS22 bid engine through its command port (C_op/C_data/C_start). On a single go pulse it performs the full session:
- load balances, mask, timer and bid cost;
- lock with a key;
- run cfg_rounds bidding rounds of fixed length, capturing maxBid and winner after each;
- unlock the engine, leaving it Unlocked.

Player bid ports are driven elsewhere. This block only owns the command port.

Parameters:
DATA_W, 32, width of C_data, key, balances, bid cost, maxBid
RND_W, 8, width of round-count and round-length fields

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
go  in  1  start-session pulse; accepted only in IDLE
cfg_key  in  DATA_W  lock/unlock key
cfg_x_init, cfg_y_init, cfg_z_init  in  DATA_W  initial balances
cfg_mask  in  3  player enable mask {X,Y,Z}
cfg_timer  in  4  engine bad-key lockout timer
cfg_bid_cost  in  DATA_W  per-bid charge
cfg_rounds  in  RND_W  rounds to run
cfg_round_len  in  RND_W  active bidding cycles per round
ready  in  1  engine ready
err  in  3  engine error (combinational from engine)
roundOver  in  1  engine round-over flag
maxBid  in  DATA_W  engine max bid
X_win, Y_win, Z_win  in  1  engine winner flags
C_op  out  4  engine opcode (registered)
C_data  out  DATA_W  engine data (registered)
C_start  out  1  engine start/round-active (registered)
busy  out  1  high from go acceptance until DONE/ERROR
done  out  1  one-cycle pulse, session complete
result_valid  out  1  one-cycle pulse, per-round result captured
last_max_bid  out  DATA_W  maxBid captured in the last OVER cycle
last_winner  out  3  {X_win,Y_win,Z_win} captured in the last OVER cycle
round_count  out  RND_W  rounds completed in this session
seq_err  out  1  sticky error flag
seq_err_code  out  3  first error cause

Behaviour:
Reset (asynchronous):
- All outputs 0, so C_op = NoOperation.
- State IDLE; latched cfg registers cleared.

States and transitions:
- IDLE: go=1 latches all cfg_*, sets busy, clears round_count.
  - cfg_rounds=0 → DONE next cycle; no engine ops issued.
  - Otherwise → CFG, op index 0.
- CFG: issues 7 ops, one per cycle, in this order:
  1. LoadX(3, x_init)
  2. LoadY(4, y_init)
  3. LoadZ(5, z_init)
  4. SetMask(6, zero-extended mask)
  5. SetTimer(7, timer)
  6. BidCharge(8, cost)
  7. Lock(2, key)
  - An op is presented only while ready=1. While ready=0, drive NoOperation and hold the index (stall, no error).
  - err is sampled at the edge ending each op cycle; err≠0 → ERROR, code 001.
  - After Lock → ROUND.
- ROUND: C_start=1, C_op=NoOperation for L+1 cycles, where L = max(cfg_round_len,1).
  - Cycle 1 is the start cycle; err≠0 there → ERROR, code 011.
  - err is ignored in the L active cycles (player-level errors).
  - Then → DRAIN.
- DRAIN: C_start=0, NoOperation, exactly 1 cycle. Engine moves to round-over → OVER.
- OVER: exactly 1 cycle.
  - roundOver must be 1, else ERROR, code 100.
  - Capture maxBid and winners; pulse result_valid; increment round_count.
  - Outputs for this cycle are registered on entry.
  - If further rounds remain: C_start=1 (this cycle is the next round's start cycle) → ROUND with L active cycles remaining.
  - Last round: C_op=Unlock(1), C_data=key; err≠0 → ERROR, code 101; else → DONE.
- DONE: pulse done, clear busy, NoOperation → IDLE.
- ERROR:
  - C_start=0, NoOperation, busy=0, seq_err=1.
  - Only the first error code is kept.
  - Exit only via reset_n.

Boundary conditions:
- go while busy: ignored.
- cfg_* changes after acceptance: ignored.
- round_count wraps only if cfg_rounds = 2^RND_W−1 is exceeded, which cannot happen.
- Reset mid-session: immediate return to IDLE; all outputs cleared.

Decomposition:
- Package bids22_pkg holds:
  - opcode constants 0–8;
  - seq state enum {IDLE, CFG, ROUND, DRAIN, OVER, DONE, ERROR};
  - seq_err_code constants 001/011/100/101;
  - engine err constants 000/001/010/011/100.
- A pure function in the package maps CFG index → (op, data).
- No sub-module.

Test Plan:
- Basic session. Stimulus: x=100, y=200, z=50, mask=111, timer=4, cost=1, rounds=1, len=2, key=0xA5A5; bench pulses X_bid with amount 10 in the first active cycle.
  Required: op trace 3,4,5,6,7,8,2; C_start high 3 cycles; DRAIN; OVER issues Unlock/0xA5A5; last_max_bid=10; last_winner=100; X_balance=89; done 13 cycles after go acceptance; busy low afterwards.
- Multi-round. Stimulus: rounds=3, len=1.
  Required: three result_valid pulses; round_count=3; exactly one Unlock issued; no Lock issued between rounds.
- Ready stall. Stimulus: go one cycle after reset_n deassertion while ready=0.
  Required: NoOperation driven until ready=1; then the full op sequence with no error.
- rounds=0.
  Required: done pulse next cycle; C_op stays 0 throughout.
- Error injection. Stimulus: bench forces err=3'b100 during the SetMask cycle.
  Required: ERROR state; seq_err=1; code 001; C_op=0 thereafter; a second go is ignored.
- Reset mid-round. Stimulus: reset_n low during ROUND.
  Required: all outputs 0 asynchronously; IDLE after release.
